// File: rtl/ob_pkg.sv
// Shared order-book command types used by the maturity receiver and its interface.
package ob_pkg;

  typedef logic [7:0] uid_t;

  typedef struct packed {
    uid_t        uid;
    logic [1:0]  op;
    logic        side;
    logic [15:0] price;
    logic [15:0] qty;
  } cmd_t;

endpackage

// File: rtl/ob_cn_mtr_rcv_if.sv
// Handshake bundle between the conditional table, host ingress, controller and ob_cn_mtr_rcv.
interface ob_cn_mtr_rcv_if;
  import ob_pkg::*;

  logic mtr_vld_r;
  cmd_t mtr_r;
  logic mtr_accept;
  logic in_vld;
  cmd_t in_cmd;
  logic in_accept;
  logic out_vld_r;
  cmd_t out_cmd_r;
  logic out_accept;
  logic cancel;
  uid_t cancel_uid;
  logic cancel_hit_w;
  logic full_r;
  logic empty_r;

  modport slave (
    input  mtr_vld_r, mtr_r, in_vld, in_cmd, out_accept, cancel, cancel_uid,
    output mtr_accept, in_accept, out_vld_r, out_cmd_r, cancel_hit_w, full_r, empty_r
  );

  modport master (
    output mtr_vld_r, mtr_r, in_vld, in_cmd, out_accept, cancel, cancel_uid,
    input  mtr_accept, in_accept, out_vld_r, out_cmd_r, cancel_hit_w, full_r, empty_r
  );

endinterface

// File: rtl/ob_cn_mtr_rcv.sv
// Matured-command receiver: cancellable FIFO for stop-triggered commands, merged with host
// commands into one registered output under fixed priority with a host anti-starvation limit.
module ob_cn_mtr_rcv #(
  parameter int unsigned N          = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  ob_cn_mtr_rcv_if.slave  bus
);
  import ob_pkg::*;

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] NFULL = CW'(N);
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);

  cmd_t          mem_q [N];
  logic [N-1:0]  live_q, live_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, empty_q;
  logic          out_vld_q, out_vld_d;
  cmd_t          out_cmd_q, out_cmd_d;
  logic [SW-1:0] streak_q, streak_d;

  logic [N-1:0]  fifo_match;
  logic          push, push_kill, pop, head_cand, dead_pop;
  logic          out_kill, ld, sel_host, issue_m, issue_h;

  always_comb begin
    fifo_match = '0;
    for (int unsigned i = 0; i < N; i++) begin
      fifo_match[i] = live_q[i] & (mem_q[i].uid == bus.cancel_uid);
    end
  end

  assign push      = bus.mtr_vld_r & ~full_q;
  assign push_kill = bus.cancel & (bus.mtr_r.uid == bus.cancel_uid);
  // A head being cancelled this cycle is not issued; it turns dead and drains next cycle.
  assign head_cand = ~empty_q & live_q[rd_ptr_q] & ~(bus.cancel & fifo_match[rd_ptr_q]);
  assign dead_pop  = ~empty_q & ~live_q[rd_ptr_q];
  assign out_kill  = bus.cancel & out_vld_q & (out_cmd_q.uid == bus.cancel_uid) & ~bus.out_accept;
  assign ld        = ~out_vld_q | bus.out_accept | out_kill;
  assign sel_host  = bus.in_vld & (~head_cand | (streak_q == SMAX));
  assign issue_m   = ld & head_cand & ~sel_host;
  assign issue_h   = ld & sel_host;
  assign pop       = issue_m | dead_pop;

  always_comb begin
    live_d = live_q & ~(fifo_match & {N{bus.cancel}});
    if (pop)  live_d[rd_ptr_q] = 1'b0;
    if (push) live_d[wr_ptr_q] = ~push_kill;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_cmd_d = out_cmd_q;
    if (ld) begin
      out_vld_d = issue_m | issue_h;
      if (issue_m)      out_cmd_d = mem_q[rd_ptr_q];
      else if (issue_h) out_cmd_d = bus.in_cmd;
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (issue_h || (ld && !bus.in_vld)) streak_d = '0;
    else if (issue_m && streak_q != SMAX) streak_d = streak_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.mtr_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      out_vld_q <= 1'b0;
      out_cmd_q <= '0;
      streak_q  <= '0;
    end else begin
      live_q    <= live_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      full_q    <= (cnt_d == NFULL);
      empty_q   <= (cnt_d == '0);
      out_vld_q <= out_vld_d;
      out_cmd_q <= out_cmd_d;
      streak_q  <= streak_d;
    end
  end

  // Host accept is suppressed in reset: a command taken then would be dropped.
  assign bus.mtr_accept   = push;
  assign bus.in_accept    = issue_h & ~rst;
  assign bus.out_vld_r    = out_vld_q;
  assign bus.out_cmd_r    = out_cmd_q;
  assign bus.cancel_hit_w = (bus.cancel & (|fifo_match)) | out_kill;
  assign bus.full_r       = full_q;
  assign bus.empty_r      = empty_q;

endmodule

// File: tb/tb_ob_cn_mtr_rcv.sv
// Self-checking bench for ob_cn_mtr_rcv: vector table for single transactions plus
// hand sequences for fill, cancel, starvation and asynchronous reset.
module tb_ob_cn_mtr_rcv;
  import ob_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ob_cn_mtr_rcv_if bif();

  ob_cn_mtr_rcv #(.N(4), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b1;
  uid_t exp_q[$];

  typedef struct {
    logic        host;
    uid_t        uid;
    int unsigned lat;
    logic        acc;
  } vec_t;

  function automatic cmd_t mk(input uid_t u);
    cmd_t c;
    c       = '0;
    c.uid   = u;
    c.op    = u[1:0];
    c.side  = u[2];
    c.price = 16'd100 + {8'd0, u};
    c.qty   = {u, 8'h01};
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic idle_in();
    bif.mtr_vld_r = 1'b0;
    bif.in_vld    = 1'b0;
    bif.cancel    = 1'b0;
  endtask

  task automatic push_m(input uid_t u);
    bif.mtr_vld_r = 1'b1;
    bif.mtr_r     = mk(u);
  endtask

  task automatic drain(input string nm);
    bif.out_accept = 1'b1;
    for (int i = 0; i < 24 && exp_q.size() != 0; i++) begin
      tick();
      neg();
    end
    repeat (3) begin
      tick();
      neg();
    end
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Scoreboard: every consumed output must match the next expected command.
  always @(negedge clk) begin
    if (!rst && mon_en && bif.out_vld_r && bif.out_accept) begin
      uid_t e;
      cmd_t ec;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_unexpected: got uid %0h required no output (t=%0t)", bif.out_cmd_r.uid, $time);
      end else begin
        e  = exp_q.pop_front();
        ec = mk(e);
        chk("out_uid", bif.out_cmd_r.uid, e);
        chk("out_price", bif.out_cmd_r.price, ec.price);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tv[5];
    logic ha, ma;
    uid_t muid, huid;

    tv[0] = '{1'b0, 8'h05, 2, 1'b1};
    tv[1] = '{1'b1, 8'h06, 1, 1'b1};
    tv[2] = '{1'b0, 8'hA5, 2, 1'b1};
    tv[3] = '{1'b1, 8'hFF, 1, 1'b1};
    tv[4] = '{1'b0, 8'h00, 2, 1'b1};

    rst            = 1'b1;
    bif.mtr_vld_r  = 1'b1;
    bif.mtr_r      = '0;
    bif.in_vld     = 1'b1;
    bif.in_cmd     = mk(8'h33);
    bif.out_accept = 1'b0;
    bif.cancel     = 1'b0;
    bif.cancel_uid = '0;

    // Reset state
    neg();
    chk("rst_out_vld", bif.out_vld_r, 0);
    chk("rst_out_cmd_zero", bif.out_cmd_r == '0, 1);
    chk("rst_empty", bif.empty_r, 1);
    chk("rst_full", bif.full_r, 0);
    chk("rst_in_accept", bif.in_accept, 0);
    chk("rst_cancel_hit", bif.cancel_hit_w, 0);
    chk("rst_mtr_accept", bif.mtr_accept, 1);
    tick();
    idle_in();
    tick();
    rst = 1'b0;
    tick();

    // Single-transaction vectors
    for (int k = 0; k < 5; k++) begin
      int unsigned seen;
      seen = 0;
      tick();
      bif.out_accept = 1'b1;
      if (tv[k].host) begin
        bif.in_vld = 1'b1;
        bif.in_cmd = mk(tv[k].uid);
      end else begin
        push_m(tv[k].uid);
      end
      exp_q.push_back(tv[k].uid);
      neg();
      chk("vec_accept", tv[k].host ? bif.in_accept : bif.mtr_accept, tv[k].acc);
      tick();
      idle_in();
      for (int c = 1; c <= 6 && seen == 0; c++) begin
        neg();
        if (bif.out_vld_r) seen = c;
        else tick();
      end
      chk("vec_latency", seen, tv[k].lat);
      tick();
      neg();
      chk("vec_empty", bif.empty_r, 1);
    end
    chk("vec_left", exp_q.size(), 0);

    // Fill: output register held, then five pushes into a depth-4 FIFO
    tick();
    bif.out_accept = 1'b0;
    push_m(8'd10);
    exp_q.push_back(8'd10);
    tick();
    idle_in();
    tick();
    neg();
    chk("fill_out_held", bif.out_vld_r, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      push_m(uid_t'(11 + i));
      neg();
      chk("fill_mtr_accept", bif.mtr_accept, (i < 4));
      chk("fill_full", bif.full_r, (i == 4));
      if (i < 4) exp_q.push_back(uid_t'(11 + i));
    end
    tick();
    idle_in();
    neg();
    chk("fill_full_hold", bif.full_r, 1);
    chk("fill_not_empty", bif.empty_r, 0);
    tick();
    drain("fill_drain_left");
    chk("fill_empty_after", bif.empty_r, 1);

    // Cancel inside the FIFO
    tick();
    bif.out_accept = 1'b0;
    push_m(8'd20);
    exp_q.push_back(8'd20);
    tick();
    idle_in();
    tick();
    push_m(8'd1);
    exp_q.push_back(8'd1);
    tick();
    push_m(8'd2);
    tick();
    push_m(8'd3);
    exp_q.push_back(8'd3);
    tick();
    idle_in();
    bif.cancel     = 1'b1;
    bif.cancel_uid = 8'd2;
    neg();
    chk("fifo_cancel_hit", bif.cancel_hit_w, 1);
    tick();
    bif.cancel_uid = 8'd9;
    neg();
    chk("fifo_cancel_miss", bif.cancel_hit_w, 0);
    tick();
    bif.cancel     = 1'b0;
    bif.out_accept = 1'b1;
    neg();
    chk("fifo_d0_vld", bif.out_vld_r, 1);
    tick();
    neg();
    chk("fifo_d1_vld", bif.out_vld_r, 1);
    tick();
    neg();
    chk("fifo_bubble", bif.out_vld_r, 0);
    tick();
    neg();
    chk("fifo_d3_vld", bif.out_vld_r, 1);
    tick();
    drain("fifo_drain_left");

    // Cancel against the output register: accept wins, then cancel without accept
    tick();
    bif.out_accept = 1'b0;
    push_m(8'd7);
    tick();
    idle_in();
    tick();
    neg();
    chk("ocan_loaded", bif.out_vld_r, 1);
    tick();
    bif.cancel     = 1'b1;
    bif.cancel_uid = 8'd7;
    bif.out_accept = 1'b1;
    exp_q.push_back(8'd7);
    neg();
    chk("ocan_accept_hit", bif.cancel_hit_w, 0);
    tick();
    bif.cancel     = 1'b0;
    bif.out_accept = 1'b0;
    neg();
    chk("ocan_consumed", bif.out_vld_r, 0);
    tick();
    push_m(8'd7);
    tick();
    idle_in();
    tick();
    neg();
    chk("ocan_reloaded", bif.out_vld_r, 1);
    tick();
    bif.cancel = 1'b1;
    neg();
    chk("ocan_hold_hit", bif.cancel_hit_w, 1);
    tick();
    bif.cancel = 1'b0;
    neg();
    chk("ocan_cleared", bif.out_vld_r, 0);
    tick();
    drain("ocan_drain_left");

    // Starvation: FIFO kept full-ish, host always waiting
    tick();
    bif.out_accept = 1'b0;
    push_m(8'd30);
    tick();
    idle_in();
    tick();
    for (int i = 0; i < 4; i++) begin
      push_m(uid_t'(31 + i));
      tick();
    end
    idle_in();
    neg();
    chk("starve_pre_full", bif.full_r, 1);
    mon_en = 1'b0;
    muid   = 8'd35;
    huid   = 8'h80;
    tick();
    bif.out_accept = 1'b1;
    bif.in_vld     = 1'b1;
    bif.in_cmd     = mk(huid);
    push_m(muid);
    for (int i = 0; i < 20; i++) begin
      neg();
      chk("starve_in_accept", bif.in_accept, (i % 5 == 4));
      chk("starve_out_src", bif.out_cmd_r.uid[7], (i == 0) ? 0 : (((i - 1) % 5) == 4));
      ha = bif.in_accept;
      ma = bif.mtr_accept;
      tick();
      if (ha) begin
        huid       = huid + 1'b1;
        bif.in_cmd = mk(huid);
      end
      if (ma) begin
        muid = muid + 1'b1;
        push_m(muid);
      end
    end
    idle_in();
    repeat (10) tick();
    neg();
    chk("starve_drained", bif.out_vld_r, 0);
    mon_en = 1'b1;
    exp_q.delete();

    // Asynchronous reset mid-burst
    tick();
    bif.out_accept = 1'b0;
    push_m(8'd40);
    tick();
    idle_in();
    tick();
    for (int i = 0; i < 3; i++) begin
      push_m(uid_t'(41 + i));
      tick();
    end
    idle_in();
    neg();
    chk("arst_pre_vld", bif.out_vld_r, 1);
    chk("arst_pre_empty", bif.empty_r, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_vld", bif.out_vld_r, 0);
    chk("arst_empty", bif.empty_r, 1);
    chk("arst_full", bif.full_r, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bif.out_accept = 1'b1;
    for (int i = 0; i < 5; i++) begin
      neg();
      chk("arst_quiet", bif.out_vld_r, 0);
      tick();
    end
    push_m(8'd44);
    exp_q.push_back(8'd44);
    tick();
    idle_in();
    drain("arst_drain_left");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ob_cn_mtr_rcv.md
# ob_cn_mtr_rcv

Receiving end of the conditional-table maturity interface. The block accepts matured (stop-triggered) commands from the conditional table's `mtr_vld_r`/`mtr_r` latch, buffers them in a small cancellable FIFO, and re-injects them into the order-book controller's command stream. It merges them with fresh host commands under a fixed-priority-with-anti-starvation arbiter. It sits between the conditional table, the host ingress, and the controller command port.

## Interface
Parameters:
- `N`, default 4: matured-command FIFO depth. Must be a power of two and ≥2.
- `STARVE_MAX`, default 4: maximum consecutive matured issues while a host command waits.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `mtr_vld_r`  in  1  matured command valid, from the table latch.
- `mtr_r`  in  `ob_pkg::cmd_t`  matured command.
- `mtr_accept`  out  1  matured command consumed this cycle.
- `in_vld`  in  1  host command valid.
- `in_cmd`  in  `ob_pkg::cmd_t`  host command.
- `in_accept`  out  1  host command consumed this cycle.
- `out_vld_r`  out  1  command valid to controller.
- `out_cmd_r`  out  `ob_pkg::cmd_t`  command to controller.
- `out_accept`  in  1  controller consumes `out_cmd_r`.
- `cancel`  in  1  cancel request.
- `cancel_uid`  in  `ob_pkg::uid_t`  UID to cancel.
- `cancel_hit_w`  out  1  cancel hit a command held in this block.
- `full_r`  out  1  FIFO holds N entries.
- `empty_r`  out  1  FIFO holds 0 entries.

## Operation
- FIFO storage: N entries, each holding `cmd_t` plus a `live` bit. Pointers are `$clog2(N)` bits and wrap naturally. Count is `$clog2(N+1)` bits.
- Push: `mtr_accept = mtr_vld_r & ~full_r`. No same-cycle credit from a pop.
- A pushed entry is written with `live=1`. It is written with `live=0` if `cancel & (mtr_r.uid == cancel_uid)` in the push cycle. The table reports that hit itself, so this block does not assert `cancel_hit_w` for it.
- Cancel of buffered entries: every entry with `live=1` and a matching UID is cleared to `live=0`.
- Cancel of the output register: `out_vld_r` with a matching UID clears `out_vld_r` next cycle, unless `out_accept` is asserted the same cycle; accept wins.
- `cancel_hit_w = cancel & (any live FIFO match | (out_vld_r & uid match & ~out_accept))`.
- Dead head (head `live=0`, count>0): popped silently in one cycle with no output. It is not a matured candidate that cycle.
- Output load condition: `ld = ~out_vld_r | out_accept`, or `out_vld_r` cleared by a cancel this cycle.
- Candidates on `ld`: M = live head, H = `in_vld`.
  - M only: issue M.
  - H only: issue H.
  - Both: issue M, unless `streak == STARVE_MAX`, in which case issue H.
- Host issue asserts `in_accept`. Host commands bypass the FIFO. Matured issue pops the head.
- `streak` counter:
  - Increments, saturating at `STARVE_MAX`, on each matured issue with `in_vld=1`.
  - Clears on a host issue, or on any `ld` cycle with `in_vld=0`.
- `in_accept = ld & H & (host selected)`. It is combinational on `in_vld`; `in_cmd` is not cancel-checked.
- Push and pop in the same cycle leave count unchanged.

## Timing
- Reset values:
  - `out_vld_r=0`, `out_cmd_r='0`, `full_r=0`, `empty_r=1`.
  - Count, pointers, `streak` and all `live` bits are 0.
  - `mtr_accept`, `in_accept` and `cancel_hit_w` are 0 while FIFO/out state is reset, except `mtr_accept` follows `mtr_vld_r & ~full_r`.
- Matured latency: push at cycle T, head visible T+1, `out_vld_r=1` at T+2 (empty FIFO, output free).
- Host latency: accept at T, `out_vld_r=1` at T+1.
- `full_r`/`empty_r` are registered from next-state count.
- Reset asserted mid-operation discards all buffered and output commands immediately (asynchronous).
- Sustained throughput is one command per cycle while `out_accept=1`.

## Test plan
- Single matured command: `mtr_vld_r=1`, uid=5 at T, empty FIFO, `out_accept=1` -> `mtr_accept=1` at T, `out_vld_r=1` with uid 5 at T+2, `empty_r=1` at T+3.
- Fill: N=4, hold `out_accept=0`, push 5 matured commands -> `full_r=1` after the fourth push, `mtr_accept=0` on the fifth, no overwrite; then drain in FIFO order.
- Cancel in FIFO: buffer uids 1,2,3, cancel uid 2 -> `cancel_hit_w=1`; output sequence 1,3 with one dead-pop bubble; cancel uid 9 -> `cancel_hit_w=0`.
- Cancel vs accept on output: `out_vld_r` uid 7, cancel uid 7 with `out_accept=1` -> command consumed, `cancel_hit_w=0`; repeat with `out_accept=0` -> `out_vld_r=0` next cycle, `cancel_hit_w=1`.
- Starvation: FIFO kept non-empty, `in_vld` held high, `STARVE_MAX=4` -> exactly 4 matured issues, then 1 host issue (`in_accept=1`), repeating.
- Async reset mid-burst: assert `rst` with 3 buffered and `out_vld_r=1` -> `out_vld_r=0`, `empty_r=1` immediately, no output after release until a new push.
